// File: rtl/dice_display_driver_pkg.sv
// Shared definitions for the dice display: FSM state encoding and segment constants.
// Segment bit order is [6:0]=a..g, [7]=dp; a set bit means "segment lit" before polarity.
package dice_display_driver_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ROLL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    // One outer segment per animation step: a, b, c, d, e, f
    localparam logic [7:0] SPIN_PAT [0:5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

endpackage

// File: rtl/dice_display_driver_seg7_digitsonly.sv
// BCD to seven-segment decoder for digits 0-9 (6 and 9 with tails).
// Codes above 9 decode to blank; callers substitute their own out-of-range glyph.
module seg7_digitsonly (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup, segments a..g in bits 0..6
    always_comb begin
        seg = 7'h00;
        case (bcd)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/dice_display_driver.sv
// Two-digit seven-segment driver for the dice roller.
// Spins an animation while a button is held, latches the result on release,
// blanks after a timeout, and multiplexes the two commons with a dead-time cycle.
module dice_display_driver
    import dice_display_driver_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 255,
    parameter int SCAN_LEN      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] digit1,
    input  logic [3:0] digit10,
    input  logic       rolling,
    input  logic       seg_active_high,
    input  logic       com_active_high,
    output logic [7:0] seg,
    output logic [1:0] com,
    output logic       lit
);

    localparam int SCAN_W = $clog2(2 * SCAN_LEN);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(2 * SCAN_LEN - 1);
    localparam logic [SCAN_W-1:0] SCAN_MID  = SCAN_W'(SCAN_LEN);
    localparam logic [7:0]        TIMER_INIT = 8'(TIMEOUT_TICKS);

    state_t            state;
    logic [7:0]        timer;
    logic [2:0]        spin;
    logic [3:0]        shadow1;
    logic [3:0]        shadow10;
    logic              rolling_q;
    logic              lit_r;
    logic [SCAN_W-1:0] scan;

    logic [7:0] seg_d, seg_r;
    logic [1:0] com_d, com_r;
    logic       slot_tens;
    logic       dead;
    logic [3:0] shown_digit;
    logic [6:0] dec_seg;

    // Handshake note: rolling is a level, tick a one-cycle strobe; neither has a ready side.
    // FSM with timer, spin and shadow digits; lit tracks the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OFF;
            timer     <= 8'd0;
            spin      <= 3'd0;
            shadow1   <= 4'd0;
            shadow10  <= 4'd0;
            rolling_q <= 1'b0;
            lit_r     <= 1'b0;
        end else begin
            rolling_q <= rolling;
            if (rolling) begin
                // A press wins over tick and timeout from any state
                state <= ST_ROLL;
                lit_r <= 1'b1;
                if (state != ST_ROLL)
                    spin <= 3'd0;
                else if (tick)
                    spin <= (spin == 3'd5) ? 3'd0 : spin + 3'd1;
            end else if (rolling_q) begin
                // Release edge: freeze the result and start the visibility window
                state    <= ST_HOLD;
                lit_r    <= 1'b1;
                shadow1  <= digit1;
                shadow10 <= digit10;
                timer    <= TIMER_INIT;
            end else if (state == ST_HOLD && tick) begin
                if (timer == 8'd1) begin
                    state <= ST_OFF;
                    timer <= 8'd0;
                    lit_r <= 1'b0;
                end else begin
                    timer <= timer - 8'd1;
                end
            end
        end
    end

    // Free-running scan position: first half ones digit, second half tens digit
    always_ff @(posedge clk) begin
        if (rst)
            scan <= '0;
        else if (scan == SCAN_LAST)
            scan <= '0;
        else
            scan <= scan + 1'b1;
    end

    assign slot_tens   = (scan >= SCAN_MID);
    assign dead        = (scan == '0) || (scan == SCAN_MID);
    assign shown_digit = slot_tens ? shadow10 : shadow1;

    seg7_digitsonly u_dec (
        .bcd (shown_digit),
        .seg (dec_seg)
    );

    // Select what the next cycle shows from the current state and scan slot
    always_comb begin
        seg_d = SEG_BLANK;
        com_d = 2'b00;
        if (!dead) begin
            if (state == ST_ROLL) begin
                seg_d = SPIN_PAT[spin];
                com_d = slot_tens ? 2'b10 : 2'b01;
            end else if (state == ST_HOLD) begin
                // Leading-zero blanking keeps the tens common off for the whole slot
                if (!(slot_tens && shadow10 == 4'd0)) begin
                    seg_d = (shown_digit > 4'd9) ? SEG_DASH : {1'b0, dec_seg};
                    com_d = slot_tens ? 2'b10 : 2'b01;
                end
            end
        end
    end

    // Output registers hold logical (active = 1) levels
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= SEG_BLANK;
            com_r <= 2'b00;
        end else begin
            seg_r <= seg_d;
            com_r <= com_d;
        end
    end

    // Pin polarity applied after the registers so cfg straps act immediately
    assign seg = seg_r ^ {8{~seg_active_high}};
    assign com = com_r ^ {2{~com_active_high}};
    assign lit = lit_r;

endmodule
